rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Owns the single register-file write port and shares it between the WB pipeline stage
//  and an out-of-order long-latency unit (LL: multiplier/divider, cache-miss refill).
//  WB has priority. LL results are buffered in a small FIFO. A starvation timer forces
//  a one-cycle WB stall so that a buffered LL result is always retired.
//  Sits between the WB stage outputs and the register file write port.
// PARAMETERS
//  DATA_W    16  register data width
//  ADDR_W    3   register address width (8 architectural registers)
//  LL_DEPTH  2   LL result FIFO depth (>=1)
//  MAX_WAIT  4   max cycles the LL FIFO head waits before a stall is forced (>=1)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       synchronous, active-high
//  wb_we        in   1       WB stage write request (holds while stall_wb=1)
//  wb_addr      in   ADDR_W  WB destination register
//  wb_data      in   DATA_W  WB result
//  wb_word      in   1       1=word write, 0=byte write (low byte, zero-extended)
//  ll_valid     in   1       LL result valid
//  ll_ready     out  1       LL FIFO can accept (from registered count only, no comb path from ll_valid)
//  ll_addr      in   ADDR_W  LL destination register
//  ll_data      in   DATA_W  LL result
//  ll_word      in   1       LL word/byte flag, same rule as wb_word
//  stall_wb     out  1       freeze WB stage register (drives enable_wb low upstream)
//  rf_we        out  1       register file write enable (registered)
//  rf_addr      out  ADDR_W  register file write address (registered)
//  rf_data      out  DATA_W  register file write data (registered, already extended)
// BEHAVIOUR
//  Reset
//  - rf_we=0, rf_addr=0, rf_data=0, stall_wb=0, FIFO empty (ll_ready=1), wait_cnt=0, state IDLE.
//  - Reset mid-operation discards buffered LL results. The LL unit must reissue them.
//  LL handshake
//  - A push happens when ll_valid && ll_ready. ll_ready = (count < LL_DEPTH).
//  - Push and pop in the same cycle are legal whenever ll_ready=1.
//  Grant, evaluated each cycle
//  - FORCE state: grant the FIFO head. wb_we is ignored because WB is held.
//  - else if wb_we: grant WB.
//  - else if FIFO is not empty: grant the FIFO head and pop it.
//  - else: no grant.
//  Write data and latency
//  - A granted request appears on rf_* one cycle later.
//  - data_out = word ? data : {8'h00, data[7:0]}. A cycle with no grant gives rf_we=0 next cycle.
//  - LL latency: pushed at cycle N, earliest rf_we at N+2. A pushed entry is not visible as head until N+1.
//  FSM (Moore output stall_wb = state==FORCE)
//  - IDLE: FIFO empty. Goes to WAIT when the count becomes non-zero.
//  - WAIT: FIFO not empty.
//    - Head granted: clear wait_cnt. Stay in WAIT if entries remain, else go to IDLE.
//    - Head not granted: increment wait_cnt. When wait_cnt reaches MAX_WAIT-1 (and head not granted), go to FORCE.
//  - FORCE: one cycle only. Head is granted and wait_cnt cleared. Go to WAIT if entries remain, else IDLE.
//  - wait_cnt width is clog2(MAX_WAIT+1). It never wraps.
//  Boundary cases
//  - FIFO full: ll_ready=0. A push is impossible even if a pop occurs this cycle.
//  - Simultaneous WB request and FORCE: WB is not consumed. It is presented again (held) next cycle and granted then.
//  - Same-destination conflict between WB and LL: writes retire in grant order. The hazard unit resolves ordering, not this block.
//  - FIFO pointers wrap modulo LL_DEPTH. The count runs from 0 to LL_DEPTH inclusive.
// STRUCTURE
//  - rf_arb_defs.vh: FSM state encodings ST_IDLE/ST_WAIT/ST_FORCE, and the byte-extend macro.
//    Shared with the hazard unit.
//  - Sub-module ll_result_fifo: synchronous FIFO (LL_DEPTH x {ADDR_W,DATA_W,1}).
//    Ports: push/pop/head/count/full/empty, same clk/reset.
//  - Top level: FSM, wait counter, grant mux, data extend, and the rf_* output register.
// TESTING
//  1. Reset held 2 cycles with wb_we=1 and ll_valid=1 -> rf_we=0, stall_wb=0, ll_ready=1 throughout.
//  2. WB only: wb_we=1, addr=5, data=16'hABCD, word=1 at N -> rf_we=1, rf_addr=5, rf_data=16'hABCD at N+1.
//     With word=0 -> rf_data=16'h00CD.
//  3. LL into idle: push addr=2, data=16'h1234 at N with wb_we=0 -> rf_we=1, rf_addr=2 at N+2. ll_ready stays 1.
//  4. Starvation (MAX_WAIT=4): wb_we=1 every cycle, one LL push at N.
//     -> stall_wb=1 exactly at N+5. LL write seen at N+6. The held WB write follows at N+7.
//  5. Full: wb_we=1 continuously, two LL pushes -> ll_ready=0 until the first forced pop.
//     A third ll_valid is not accepted while ll_ready=0. No entry is lost or duplicated.
//  6. Reset with 2 entries buffered -> FIFO empty, state IDLE, no rf_we afterwards without a new request.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared state encodings and constants for the RF write arbiter
// Purpose : arbiter FSM state encodings, grant-source encoding and the byte width
//           used by the byte-write zero-extension. Also imported by the hazard unit.
// Ports   : none (package)
package rf_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_LL   = 2'd2
    } gnt_src_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/ll_result_fifo.sv
// rtl/ll_result_fifo.sv - synchronous FIFO buffering long-latency results
// Purpose : DEPTH-entry FIFO of {addr, data, word}; push into the tail, pop the head.
//           Pushes while full and pops while empty are ignored.
// Ports   : clk, reset (sync, active-high)
//           push, push_addr, push_data, push_word  - write side
//           pop                                     - remove head
//           head_addr, head_data, head_word         - current head entry
//           count, full, empty                      - registered occupancy
module ll_result_fifo #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_word,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              head_word,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = ADDR_W + DATA_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign {head_addr, head_data, head_word} = mem_q[rd_ptr_q];

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = {push_addr, push_data, push_word};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: it is only read once count marks it valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port between WB and the LL unit
// Purpose : WB has priority; LL results are buffered in ll_result_fifo. If the FIFO head
//           waits MAX_WAIT cycles, WB is stalled for one cycle (FORCE) to retire it.
// Ports   : clk, reset (sync, active-high)
//           wb_we/wb_addr/wb_data/wb_word   - WB stage write request (held while stall_wb)
//           ll_valid/ll_ready/ll_addr/ll_data/ll_word - LL result handshake
//           stall_wb                        - freezes the WB stage register
//           rf_we/rf_addr/rf_data           - registered register-file write port
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int LL_DEPTH = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_word,
    input  logic              ll_valid,
    output logic              ll_ready,
    input  logic [ADDR_W-1:0] ll_addr,
    input  logic [DATA_W-1:0] ll_data,
    input  logic              ll_word,
    output logic              stall_wb,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data
);

    localparam int CNT_W  = $clog2(LL_DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_e         state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]  rf_data_q, rf_data_d;

    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic               head_word;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    gnt_src_e           gnt;
    logic               gnt_ll;
    logic [CNT_W:0]     count_nxt;
    logic               entries_remain;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_word;

    // ll_ready depends only on the registered count, never on ll_valid.
    assign ll_ready = !fifo_full;
    assign push     = ll_valid && ll_ready;

    ll_result_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (LL_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_addr (ll_addr),
        .push_data (ll_data),
        .push_word (ll_word),
        .pop       (gnt_ll),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_word (head_word),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Grant: FORCE overrides a (held) WB request; otherwise WB wins over the FIFO head.
    always_comb begin
        gnt = GNT_NONE;
        if (state_q == ST_FORCE && !fifo_empty) begin
            gnt = GNT_LL;
        end else if (wb_we) begin
            gnt = GNT_WB;
        end else if (!fifo_empty) begin
            gnt = GNT_LL;
        end
    end

    assign gnt_ll         = (gnt == GNT_LL);
    assign count_nxt      = {1'b0, fifo_count} + (CNT_W+1)'(push) - (CNT_W+1)'(gnt_ll);
    assign entries_remain = (count_nxt != '0);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (entries_remain) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gnt_ll) begin
                    wait_cnt_d = '0;
                    state_d    = entries_remain ? ST_WAIT : ST_IDLE;
                end else begin
                    // Counter stops at MAX_WAIT at most: FORCE clears it next cycle.
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                wait_cnt_d = '0;
                state_d    = entries_remain ? ST_WAIT : ST_IDLE;
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    assign stall_wb = (state_q == ST_FORCE);

    // Output register: address/data hold when nothing is granted; only rf_we drops.
    always_comb begin
        sel_data  = gnt_ll ? head_data : wb_data;
        sel_word  = gnt_ll ? head_word : wb_word;
        rf_we_d   = (gnt != GNT_NONE);
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (gnt != GNT_NONE) begin
            rf_addr_d = gnt_ll ? head_addr : wb_addr;
            rf_data_d = sel_word ? sel_data
                                 : {{(DATA_W-BYTE_W){1'b0}}, sel_data[BYTE_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_word;
    logic        ll_valid;
    logic        ll_ready;
    logic [2:0]  ll_addr;
    logic [15:0] ll_data;
    logic        ll_word;
    logic        stall_wb;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .DATA_W   (16),
        .ADDR_W   (3),
        .LL_DEPTH (2),
        .MAX_WAIT (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_word  (wb_word),
        .ll_valid (ll_valid),
        .ll_ready (ll_ready),
        .ll_addr  (ll_addr),
        .ll_data  (ll_data),
        .ll_word  (ll_word),
        .stall_wb (stall_wb),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_addr = 0; wb_data = 0; wb_word = 1;
        ll_valid = 0; ll_addr = 0; ll_data = 0; ll_word = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; wb_we = 1; wb_addr = 3'd7; wb_data = 16'hFFFF;
        ll_valid = 1; ll_addr = 3'd6; ll_data = 16'hEEEE;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we cyc%0d got=%b exp=0", i, rf_we); end
            n_checks++;
            if (stall_wb !== 1'b0) begin n_fail++; $display("FAIL reset_stall cyc%0d got=%b exp=0", i, stall_wb); end
            n_checks++;
            if (ll_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ll_ready cyc%0d got=%b exp=1", i, ll_ready); end
            n_checks++;
            if (rf_addr !== 3'd0 || rf_data !== 16'h0) begin
                n_fail++; $display("FAIL reset_rf_bus cyc%0d got=%h/%h exp=0/0000", i, rf_addr, rf_data);
            end
        end
        idle_inputs();
        reset = 0;
    endtask

    task automatic test_wb_only();
        do_reset();
        wb_we = 1; wb_addr = 3'd5; wb_data = 16'hABCD; wb_word = 1;
        step();
        n_checks++;
        if (rf_we !== 1'b1 || rf_addr !== 3'd5 || rf_data !== 16'hABCD) begin
            n_fail++; $display("FAIL wb_word got=%b/%h/%h exp=1/5/abcd", rf_we, rf_addr, rf_data);
        end
        wb_word = 0;
        step();
        n_checks++;
        if (rf_we !== 1'b1 || rf_addr !== 3'd5 || rf_data !== 16'h00CD) begin
            n_fail++; $display("FAIL wb_byte got=%b/%h/%h exp=1/5/00cd", rf_we, rf_addr, rf_data);
        end
        wb_we = 0;
        step();
        n_checks++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL wb_no_grant got=%b exp=0", rf_we); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  va [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [15:0] vd [4] = '{16'h1357, 16'h2468, 16'h9A9A, 16'hF00F};
        logic        vw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] ve [4] = '{16'h1357, 16'h0068, 16'h009A, 16'hF00F};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wb_we = 1; wb_addr = va[i]; wb_data = vd[i]; wb_word = vw[i];
            step();
            n_checks++;
            if (rf_we !== 1'b1 || rf_addr !== va[i] || rf_data !== ve[i]) begin
                n_fail++; $display("FAIL b2b_%0d got=%b/%h/%h exp=1/%h/%h", i, rf_we, rf_addr, rf_data, va[i], ve[i]);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_ll_idle();
        do_reset();
        ll_valid = 1; ll_addr = 3'd2; ll_data = 16'h1234; ll_word = 1;
        n_checks++;
        if (ll_ready !== 1'b1) begin n_fail++; $display("FAIL ll_idle_ready0 got=%b exp=1", ll_ready); end
        step();
        ll_valid = 0;
        n_checks++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL ll_idle_n1 rf_we got=%b exp=0", rf_we); end
        n_checks++;
        if (ll_ready !== 1'b1) begin n_fail++; $display("FAIL ll_idle_ready1 got=%b exp=1", ll_ready); end
        step();
        n_checks++;
        if (rf_we !== 1'b1 || rf_addr !== 3'd2 || rf_data !== 16'h1234) begin
            n_fail++; $display("FAIL ll_idle_n2 got=%b/%h/%h exp=1/2/1234", rf_we, rf_addr, rf_data);
        end
        step();
        n_checks++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL ll_idle_n3 rf_we got=%b exp=0", rf_we); end
    endtask

    task automatic test_starvation();
        logic exp_stall;
        logic exp_ll;
        do_reset();
        wb_we = 1; wb_addr = 3'd1; wb_data = 16'h5A5A; wb_word = 1;
        for (int c = 0; c < 8; c++) begin
            ll_valid = (c == 0); ll_addr = 3'd3; ll_data = 16'hC3C3; ll_word = 0;
            exp_stall = (c == 5);
            n_checks++;
            if (stall_wb !== exp_stall) begin
                n_fail++; $display("FAIL starve_stall cyc%0d got=%b exp=%b", c, stall_wb, exp_stall);
            end
            step();
            exp_ll = (c + 1 == 6);
            n_checks++;
            if (exp_ll && (rf_we !== 1'b1 || rf_addr !== 3'd3 || rf_data !== 16'h00C3)) begin
                n_fail++; $display("FAIL starve_ll cyc%0d got=%b/%h/%h exp=1/3/00c3", c + 1, rf_we, rf_addr, rf_data);
            end else if (!exp_ll && (rf_we !== 1'b1 || rf_addr !== 3'd1 || rf_data !== 16'h5A5A)) begin
                n_fail++; $display("FAIL starve_wb cyc%0d got=%b/%h/%h exp=1/1/5a5a", c + 1, rf_we, rf_addr, rf_data);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_full();
        int          exp_cyc  [3] = '{6, 11, 16};
        logic [2:0]  exp_addr [3] = '{3'd4, 3'd5, 3'd6};
        logic [15:0] exp_data [3] = '{16'hAAAA, 16'hBBBB, 16'h00CC};
        int   ll_cnt = 0;
        logic exp_ready;
        logic exp_stall;
        do_reset();
        wb_we = 1; wb_addr = 3'd1; wb_data = 16'h1111; wb_word = 1;
        for (int c = 0; c < 20; c++) begin
            ll_valid = 0; ll_word = 1;
            if (c == 0) begin ll_valid = 1; ll_addr = 3'd4; ll_data = 16'hAAAA; end
            else if (c == 1) begin ll_valid = 1; ll_addr = 3'd5; ll_data = 16'hBBBB; end
            else if (c <= 6) begin ll_valid = 1; ll_addr = 3'd6; ll_data = 16'hCCCC; ll_word = 0; end
            if (c <= 6) begin
                exp_ready = (c <= 1) || (c == 6);
                n_checks++;
                if (ll_ready !== exp_ready) begin
                    n_fail++; $display("FAIL full_ready cyc%0d got=%b exp=%b", c, ll_ready, exp_ready);
                end
            end
            exp_stall = (c == 5) || (c == 10) || (c == 15);
            n_checks++;
            if (stall_wb !== exp_stall) begin
                n_fail++; $display("FAIL full_stall cyc%0d got=%b exp=%b", c, stall_wb, exp_stall);
            end
            step();
            if (rf_we === 1'b1 && rf_addr !== 3'd1) begin
                if (ll_cnt < 3) begin
                    n_checks++;
                    if (c + 1 != exp_cyc[ll_cnt] || rf_addr !== exp_addr[ll_cnt] || rf_data !== exp_data[ll_cnt]) begin
                        n_fail++;
                        $display("FAIL full_ll_%0d got=cyc%0d/%h/%h exp=cyc%0d/%h/%h", ll_cnt, c + 1, rf_addr, rf_data,
                                 exp_cyc[ll_cnt], exp_addr[ll_cnt], exp_data[ll_cnt]);
                    end
                end
                ll_cnt++;
            end
        end
        n_checks++;
        if (ll_cnt != 3) begin n_fail++; $display("FAIL full_ll_count got=%0d exp=3", ll_cnt); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_buffered();
        do_reset();
        wb_we = 1; wb_addr = 3'd1; wb_data = 16'h1111;
        ll_valid = 1; ll_addr = 3'd4; ll_data = 16'h4444;
        step();
        ll_addr = 3'd5; ll_data = 16'h5555;
        step();
        ll_valid = 0;
        n_checks++;
        if (ll_ready !== 1'b0) begin n_fail++; $display("FAIL rstbuf_full got=%b exp=0", ll_ready); end
        wb_we = 0;
        reset = 1;
        step();
        reset = 0;
        n_checks++;
        if (ll_ready !== 1'b1 || stall_wb !== 1'b0) begin
            n_fail++; $display("FAIL rstbuf_after got=%b/%b exp=1/0", ll_ready, stall_wb);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (rf_we !== 1'b0 || stall_wb !== 1'b0) begin
                n_fail++; $display("FAIL rstbuf_quiet cyc%0d got=%b/%b exp=0/0", i, rf_we, stall_wb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_back_to_back();
        test_ll_idle();
        test_starvation();
        test_full();
        test_reset_buffered();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
